// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter for the read port of a shared FIFO.
// One consumer is granted at a time; up to BURST_LEN reads are strobed on its behalf.
module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    rdy_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rd_en_o,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    dvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  burst_done_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [IW:0]   NREQ_W   = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] BL_W     = CW'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  dvalid_q, dvalid_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       beat_q, beat_d;
    logic                done_q, done_d;

    logic                rd_en;
    logic [CW-1:0]       beat_next;
    logic [IW:0]         cand;
    logic [IW-1:0]       pick_idx;
    logic                pick_vld;

    // Rotating scan starting at ptr_q; first requester found wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW + 1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!pick_vld && req_i[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IW-1:0];
            end
        end
    end

    assign rd_en = (state_q == BURST) & req_i[gidx_q] & rdy_i[gidx_q]
                 & ~fifo_empty_i & (beat_q < BL_W);
    assign beat_next = beat_q + CW'(rd_en);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        done_d   = 1'b0;
        dvalid_d = rd_en ? gnt_q : '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gidx_d  = pick_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                beat_d = beat_next;
                if ((beat_next == BL_W) || !req_i[gidx_q]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Grant was held one extra cycle so the last beat lands.
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = 1'b1;
                ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            dvalid_q <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            dvalid_q <= dvalid_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign gnt_o        = gnt_q;
    assign dvalid_o     = dvalid_q;
    assign rdata_o      = fifo_rdata_i;
    assign burst_done_o = done_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: directed scenarios push expected grants and beats,
// a forked monitor pops and compares whenever the DUT presents a grant or a data beat.
module tb_fifo_rd_arbiter;
    localparam int N  = 4;
    localparam int BL = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, rdy, gnt, dvalid;
    logic          fifo_empty, rd_en, bdone;
    logic [DW-1:0] fifo_rdata = '0;
    logic [DW-1:0] rdata;
    logic          force_empty;

    always #5 clk = ~clk;

    fifo_rd_arbiter #(.NUM_REQ(N), .BURST_LEN(BL), .DATA_WIDTH(DW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .rdy_i        (rdy),
        .fifo_empty_i (fifo_empty),
        .fifo_rdata_i (fifo_rdata),
        .fifo_rd_en_o (rd_en),
        .gnt_o        (gnt),
        .dvalid_o     (dvalid),
        .rdata_o      (rdata),
        .burst_done_o (bdone)
    );

    // FIFO model: data appears one cycle after the read strobe.
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr) || force_empty;

    always @(posedge clk) begin
        if (rd_en) begin
            fifo_rdata <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Strobe tracker: beats per released grant and cycle gaps between strobes.
    int cyc = 0;
    int burst_cnt = 0;
    int last_strobe = -1;
    int lens[$];
    int gaps[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            burst_cnt   <= 0;
            last_strobe <= -1;
            lens.delete();
            gaps.delete();
        end else begin
            if (rd_en) begin
                burst_cnt <= burst_cnt + 1;
                if (last_strobe >= 0) gaps.push_back(cyc - last_strobe);
                last_strobe <= cyc;
            end
            if (bdone) begin
                lens.push_back(burst_cnt);
                burst_cnt <= 0;
            end
        end
    end

    logic [N-1:0]  exp_gnt[$];
    int            exp_idx[$];
    logic [DW-1:0] exp_dat[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [N-1:0] prev_gnt;
        logic         prev_rd, prev_rst;
        int           idx;
        logic [DW-1:0] d;
        prev_gnt = '0;
        prev_rd  = 1'b0;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt !== prev_gnt && gnt != '0) begin
                if (exp_gnt.size() == 0) chk("unexpected_grant", 32'(gnt), 0);
                else                     chk("grant_order", 32'(gnt), 32'(exp_gnt.pop_front()));
            end
            chk("gnt_onehot0", $onehot0(gnt) ? 1 : 0, 1);
            chk("dvalid_onehot0", $onehot0(dvalid) ? 1 : 0, 1);
            chk("dvalid_trails_strobe", 32'(dvalid), (prev_rd && !prev_rst) ? 32'(prev_gnt) : 0);
            if (fifo_empty) chk("underflow_guard", 32'(rd_en), 0);
            if (dvalid != '0) begin
                if (exp_idx.size() == 0) begin
                    chk("unexpected_beat", 32'(dvalid), 0);
                end else begin
                    idx = exp_idx.pop_front();
                    d   = exp_dat.pop_front();
                    chk("beat_index", 32'(dvalid), 32'(1) << idx);
                    chk("beat_data", 32'(rdata), 32'(d));
                end
            end
            prev_gnt = gnt;
            prev_rd  = rd_en;
            prev_rst = rst;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rdy = '1; force_empty = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic load(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_ptr[7:0]] = 8'(base + k);
            wr_ptr++;
        end
    endtask

    task automatic beats(input int idx, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_idx.push_back(idx);
            exp_dat.push_back(8'(base + k));
        end
    endtask

    task automatic wait_strobes(input int n);
        int t = 0;
        while (burst_cnt < n && t < 100) begin tick(); t++; end
        chk("wait_strobes_timeout", burst_cnt, n);
    endtask

    // Let the FIFO drain, drop all requests, wait for the grant release.
    task automatic finish_test();
        int t = 0;
        while (wr_ptr != rd_ptr && t < 300) begin tick(); t++; end
        chk("drain_timeout", (wr_ptr == rd_ptr) ? 1 : 0, 1);
        req = '0;
        t = 0;
        while (!bdone && t < 20) begin tick(); t++; end
        chk("release_timeout", 32'(bdone), 1);
        tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_dvalid", 32'(dvalid), 0);
        chk("reset_rd_en", 32'(rd_en), 0);
        chk("reset_burst_done", 32'(bdone), 0);
        fork monitor(); join_none

        // Single consumer, 20 words: bursts of 8, 8, 4.
        repeat (3) exp_gnt.push_back(4'b0001);
        beats(0, 8'h10, 20);
        load(8'h10, 20);
        req = 4'b0001;
        tick();
        chk("t1_grant_latency", 32'(gnt), 32'h1);
        finish_test();
        chk("t1_bursts", lens.size(), 3);
        if (lens.size() == 3) begin
            chk("t1_len0", lens[0], 8);
            chk("t1_len1", lens[1], 8);
            chk("t1_len2", lens[2], 4);
        end

        // All four requesting: order 0,1,2,3,0, two idle cycles between bursts.
        do_reset();
        exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010);
        exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000);
        exp_gnt.push_back(4'b0001);
        for (int b = 0; b < 5; b++) beats(b % 4, 8'h40 + 8 * b, 8);
        load(8'h40, 40);
        req = 4'b1111;
        finish_test();
        chk("t2_bursts", lens.size(), 5);
        foreach (lens[i]) chk("t2_len", lens[i], 8);
        chk("t2_gap_count", gaps.size(), 39);
        foreach (gaps[i]) chk("t2_gap", gaps[i], ((i % 8) == 7) ? 3 : 1);

        // Consumer 2 stalled by an empty FIFO for 5 cycles after beat 3.
        do_reset();
        exp_gnt.push_back(4'b0100);
        beats(2, 8'h90, 8);
        load(8'h90, 8);
        req = 4'b0100;
        wait_strobes(3);
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_no_strobe_when_empty", 32'(rd_en), 0);
            chk("t3_grant_held", 32'(gnt), 32'h4);
            tick();
        end
        chk("t3_beats_during_stall", burst_cnt, 3);
        force_empty = 1'b0;
        finish_test();
        chk("t3_bursts", lens.size(), 1);
        if (lens.size() == 1) chk("t3_len", lens[0], 8);

        // Consumer 1 drops after its 6th strobe; next scan starts at 2 so 3 wins over 0.
        do_reset();
        exp_gnt.push_back(4'b0010); exp_gnt.push_back(4'b1000);
        beats(1, 8'hA0, 6);
        beats(3, 8'hA6, 8);
        load(8'hA0, 14);
        req = 4'b0010;
        wait_strobes(6);
        req = 4'b1001;
        finish_test();
        chk("t4_bursts", lens.size(), 2);
        if (lens.size() == 2) begin
            chk("t4_len0", lens[0], 6);
            chk("t4_len1", lens[1], 8);
        end

        // rdy_i[0] toggling: strobes only in ready cycles, 8 strobes total.
        do_reset();
        exp_gnt.push_back(4'b0001);
        beats(0, 8'hC0, 8);
        load(8'hC0, 8);
        req = 4'b0001;
        tick();
        begin
            int nb = 0;
            for (int i = 0; i < 16; i++) begin
                rdy = ((i % 2) == 0) ? 4'b1111 : 4'b1110;
                #1;
                chk("t5_strobe_vs_rdy", 32'(rd_en), (((i % 2) == 0) && nb < 8) ? 1 : 0);
                if (((i % 2) == 0) && nb < 8) nb++;
                tick();
            end
        end
        rdy = '1;
        finish_test();
        chk("t5_bursts", lens.size(), 1);
        if (lens.size() == 1) chk("t5_len", lens[0], 8);

        // Reset during the 4th strobe: beat 4 is lost, consumer 3 granted after release.
        do_reset();
        exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000);
        beats(2, 8'hD0, 3);
        beats(3, 8'hD4, 4);
        load(8'hD0, 8);
        req = 4'b0100;
        wait_strobes(3);
        rst = 1'b1;
        #1;
        chk("t6_strobe4_issued", 32'(rd_en), 1);
        tick();
        rst = 1'b0;
        req = 4'b1000;
        chk("t6_gnt_after_rst", 32'(gnt), 0);
        chk("t6_dvalid_after_rst", 32'(dvalid), 0);
        chk("t6_rd_en_after_rst", 32'(rd_en), 0);
        chk("t6_done_after_rst", 32'(bdone), 0);
        tick();
        chk("t6_regrant_latency", 32'(gnt), 32'h8);
        finish_test();
        chk("t6_bursts", lens.size(), 1);
        if (lens.size() == 1) chk("t6_len", lens[0], 4);

        chk("sb_beats_left", exp_idx.size(), 0);
        chk("sb_grants_left", exp_gnt.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
Round-robin burst arbiter that shares the read port of the asynchronous FIFO among NUM_REQ consumers in the read clock domain. It grants one consumer at a time and issues up to BURST_LEN read strobes to the FIFO on that consumer's behalf. It routes the returned data to the granted consumer with a per-consumer valid. It sits between the FIFO read side and the consumers, and drives the FIFO read enable directly.

Parameters:
NUM_REQ, 4, number of consumers sharing the FIFO read port (>=2)
BURST_LEN, 8, maximum reads per grant (>=1)
DATA_WIDTH, 8, FIFO data width

Ports:
clk_i  input  1  read-domain clock; all logic on rising edge
rst_i  input  1  synchronous, active-high reset
req_i  input  NUM_REQ  per-consumer request; level, held while the consumer wants data
rdy_i  input  NUM_REQ  per-consumer ready to accept a beat
fifo_empty_i  input  1  FIFO empty flag
fifo_rdata_i  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en_o
fifo_rd_en_o  output  1  FIFO read enable
gnt_o  output  NUM_REQ  one-hot grant, registered
dvalid_o  output  NUM_REQ  one-hot data valid for the granted consumer
rdata_o  output  DATA_WIDTH  data to consumers; combinational pass-through of fifo_rdata_i
burst_done_o  output  1  one-cycle pulse when a grant is released

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, gnt_o=0, dvalid_o=0, fifo_rd_en_o=0, burst_done_o=0, beat_cnt=0, priority pointer ptr=0.
- Reset mid-burst: the grant is dropped immediately. The dvalid_o for a read strobed in the previous cycle is suppressed. The FIFO pointer has already advanced, and that beat is lost by design.
- Reset dominates all other inputs.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - If req_i!=0, select the first set req_i bit scanning ptr, ptr+1, ... mod NUM_REQ.
  - Register gnt_o to that one-hot value, set beat_cnt=0, go to BURST. Grant latency is 1 cycle after the request is seen.
  - Otherwise stay in IDLE.
- BURST with granted index g:
  - fifo_rd_en_o = req_i[g] & rdy_i[g] & !fifo_empty_i & (beat_cnt<BURST_LEN). This is combinational from registered state plus inputs.
  - Each cycle fifo_rd_en_o=1, beat_cnt increments. beat_cnt width is $clog2(BURST_LEN+1) and never wraps.
  - fifo_empty_i=1 or rdy_i[g]=0 stalls: the grant is held, no strobe is issued, and there is no timeout.
  - Go to DRAIN when, at a clock edge, beat_cnt reaches BURST_LEN (including the increment this cycle) or req_i[g]=0.
  - A read strobed in the same cycle that req_i[g] falls still completes.
- DRAIN:
  - fifo_rd_en_o=0, and gnt_o stays asserted so the final beat's data is delivered.
  - After one cycle: gnt_o=0, burst_done_o pulses, ptr=(g+1) mod NUM_REQ, go to IDLE.
  - Arbitration for the next grant happens in IDLE on the following cycle. Minimum gap between grants is 2 cycles.
- Data return: dvalid_o[g] is a register of fifo_rd_en_o, asserted exactly one cycle after each strobe, at the index granted when the strobe was issued.
- Underflow guard: fifo_rd_en_o is never 1 when fifo_empty_i=1, in any state.
- Fairness: a consumer holding req_i continuously is granted within NUM_REQ-1 intervening bursts.
- req_i changes on non-granted lines during BURST/DRAIN have no effect until IDLE.
- Multiple simultaneous requests in IDLE: exactly one grant, chosen per ptr.
- Invariant: gnt_o and dvalid_o are always one-hot or zero.

Test Plan:
- Single consumer, FIFO holds 20 words, req_i=0001, rdy_i=1111, BURST_LEN=8 -> reads split 8,8,4. Each dvalid_o[0] trails fifo_rd_en_o by 1 cycle. burst_done_o pulses 3 times. rdata_o sequence matches the FIFO order.
- All four requesting continuously from reset, FIFO never empty -> grant order 0,1,2,3,0. Each burst is 8 beats. Gap of 2 cycles between grants.
- Granted consumer 2 with fifo_empty_i=1 after beat 3 for 5 cycles -> no fifo_rd_en_o while empty, gnt_o=0100 held, beats resume when empty drops, burst totals 8.
- Consumer 1 drops req_i after beat 5 (same cycle as a strobe) -> 6th strobe completes, dvalid_o[1] seen 6 times, DRAIN, grant moves to the next requester scanning from 2.
- rdy_i[0] toggling 1,0,1,0 during a burst -> strobes only in rdy=1 cycles, beat_cnt counts only strobes.
- rst_i asserted mid-burst at beat 4 -> next cycle all outputs 0, ptr=0, no dvalid_o for the beat-4 strobe. After release, a re-request by consumer 3 alone is granted 1 cycle later.
